// File: rtl/hamming_pkg.sv
// Hamming(15,11) link shared definitions: widths, parity positions,
// data-to-codeword position table and the transmitter FSM states.
package hamming_pkg;

    localparam int DADO_W     = 11;
    localparam int CODIGO_W   = 15;
    localparam int PARIDADE_W = 4;

    // Codeword indices (0-based) that hold the parity bits.
    localparam int POS_PARIDADE [PARIDADE_W] = '{0, 1, 3, 7};

    // Codeword index for each data bit d0..d10.
    localparam int POS_DADO [DADO_W] =
        '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        TRANSMITE = 2'd1,
        GUARDA    = 2'd2
    } estado_t;

endpackage

// File: rtl/codifica_hamming.sv
// Combinational Hamming(15,11) encoder, no error injection.
// Ports: dado_i (11-bit data in), codigo_o (15-bit codeword out).
module codifica_hamming
    import hamming_pkg::*;
(
    input  logic [DADO_W-1:0]   dado_i,
    output logic [CODIGO_W-1:0] codigo_o
);

    always_comb begin
        logic [CODIGO_W-1:0] c;
        logic                par;
        c = '0;
        for (int i = 0; i < DADO_W; i++) begin
            c[POS_DADO[i]] = dado_i[i];
        end
        // Parity p covers every position whose 1-based index has bit p
        // set; parity slots are still 0 here so they drop out of the XOR.
        for (int p = 0; p < PARIDADE_W; p++) begin
            par = 1'b0;
            for (int i = 0; i < CODIGO_W; i++) begin
                if (((i + 1) >> p) % 2 == 1) begin
                    par = par ^ c[i];
                end
            end
            c[POS_PARIDADE[p]] = par;
        end
        codigo_o = c;
    end

endmodule

// File: rtl/transmissor_hamming.sv
// Hamming(15,11) transmitter: valid/ready intake, encode, optional
// single-bit injection, parallel strobe and LSB-first serial output.
// Ports: clk, rst (sync, active-high); dado/dado_valido/dado_pronto
// handshake with erro_pos; codigo/codigo_valido parallel result;
// tx_bit/tx_ativo/tx_inicio serial stream; quadros frame counter.
module transmissor_hamming
    import hamming_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 1,
    parameter int CICLOS_GUARDA  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DADO_W-1:0]   dado,
    input  logic                dado_valido,
    output logic                dado_pronto,
    input  logic [3:0]          erro_pos,
    output logic [CODIGO_W-1:0] codigo,
    output logic                codigo_valido,
    output logic                tx_bit,
    output logic                tx_ativo,
    output logic                tx_inicio,
    output logic [15:0]         quadros
);

    localparam int DIV_W = (CICLOS_POR_BIT > 1) ?
                           $clog2(CICLOS_POR_BIT) : 1;
    localparam int GUA_W = (CICLOS_GUARDA > 1) ?
                           $clog2(CICLOS_GUARDA) : 1;
    localparam logic [DIV_W-1:0] DIV_FIM =
        DIV_W'(CICLOS_POR_BIT - 1);
    localparam logic [GUA_W-1:0] GUA_FIM =
        GUA_W'((CICLOS_GUARDA > 0) ? CICLOS_GUARDA - 1 : 0);
    localparam logic [3:0] BIT_FIM = 4'(CODIGO_W - 1);

    estado_t             estado_q, estado_d;
    logic [3:0]          bit_q, bit_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [GUA_W-1:0]    guarda_q, guarda_d;
    logic [15:0]         quadros_q, quadros_d;
    logic [CODIGO_W-1:0] codigo_q, codigo_d;
    logic                valido_q, valido_d;
    logic                pronto_q, pronto_d;
    logic [CODIGO_W-1:0] codigo_enc;
    logic [CODIGO_W-1:0] mascara;
    logic                aceita;

    codifica_hamming u_codifica (
        .dado_i   (dado),
        .codigo_o (codigo_enc)
    );

    // erro_pos is 1-based; 0 means no injection.
    always_comb begin
        mascara = '0;
        if (erro_pos != 4'd0) begin
            mascara[erro_pos - 4'd1] = 1'b1;
        end
    end

    assign aceita = dado_valido && pronto_q;

    always_comb begin
        estado_d  = estado_q;
        bit_d     = bit_q;
        div_d     = div_q;
        guarda_d  = guarda_q;
        quadros_d = quadros_q;
        codigo_d  = codigo_q;
        valido_d  = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (aceita) begin
                    codigo_d = codigo_enc ^ mascara;
                    valido_d = 1'b1;
                    bit_d    = 4'd0;
                    div_d    = '0;
                    estado_d = TRANSMITE;
                end
            end
            TRANSMITE: begin
                if (div_q == DIV_FIM) begin
                    div_d = '0;
                    if (bit_q == BIT_FIM) begin
                        quadros_d = quadros_q + 16'd1;
                        guarda_d  = '0;
                        estado_d  = (CICLOS_GUARDA == 0) ?
                                    OCIOSO : GUARDA;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GUARDA: begin
                if (guarda_q == GUA_FIM) begin
                    estado_d = OCIOSO;
                end else begin
                    guarda_d = guarda_q + GUA_W'(1);
                end
            end
            default: estado_d = OCIOSO;
        endcase
        // Ready only after a full cycle settled in OCIOSO, so it is
        // low during reset and rises one cycle after returning idle.
        pronto_d = (estado_q == OCIOSO) && (estado_d == OCIOSO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            bit_q     <= 4'd0;
            div_q     <= '0;
            guarda_q  <= '0;
            quadros_q <= 16'd0;
            codigo_q  <= '0;
            valido_q  <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            guarda_q  <= guarda_d;
            quadros_q <= quadros_d;
            codigo_q  <= codigo_d;
            valido_q  <= valido_d;
            pronto_q  <= pronto_d;
        end
    end

    assign tx_ativo      = (estado_q == TRANSMITE);
    assign tx_bit        = tx_ativo && codigo_q[bit_q];
    assign tx_inicio     = tx_ativo && (bit_q == 4'd0);
    assign dado_pronto   = pronto_q;
    assign codigo        = codigo_q;
    assign codigo_valido = valido_q;
    assign quadros       = quadros_q;

endmodule
